// File: rtl/dest_tag_pipeline_if.sv
`default_nettype none
// ============================================================================
// Module      : dest_tag_pipeline_if
// Description : ID-side inputs and EX/MEM/WB tag outputs exchanged between the
//               decode stage, the destination-tag pipeline and the hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface dest_tag_pipeline_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    // ID-stage instruction attributes and pipeline control
    logic [REG_ADDR_W-1:0]      id_destination;
    logic                       id_rf_enable;
    logic                       id_load_instruction;
    logic                       nop_signal;
    logic                       flush;
    logic                       hold;

    // Stage tags presented to the hazard/forwarding unit
    logic [REG_ADDR_W-1:0]      ex_destination;
    logic [REG_ADDR_W-1:0]      mem_destination;
    logic [REG_ADDR_W-1:0]      wb_destination;
    logic                       ex_rf_enable;
    logic                       mem_rf_enable;
    logic                       wb_rf_enable;
    logic                       ex_load_instruction;
    logic                       mem_load_instruction;
    logic [(2**REG_ADDR_W)-1:0] pending_mask;
    logic [CNT_W-1:0]           bubble_count;
    logic [CNT_W-1:0]           hold_count;

    modport master (
        output id_destination, id_rf_enable, id_load_instruction,
        output nop_signal, flush, hold,
        input  ex_destination, mem_destination, wb_destination,
        input  ex_rf_enable, mem_rf_enable, wb_rf_enable,
        input  ex_load_instruction, mem_load_instruction,
        input  pending_mask, bubble_count, hold_count
    );

    modport slave (
        input  id_destination, id_rf_enable, id_load_instruction,
        input  nop_signal, flush, hold,
        output ex_destination, mem_destination, wb_destination,
        output ex_rf_enable, mem_rf_enable, wb_rf_enable,
        output ex_load_instruction, mem_load_instruction,
        output pending_mask, bubble_count, hold_count
    );
endinterface
`default_nettype wire

// File: rtl/dest_tag_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : dest_tag_pipeline
// Description : Carries destination tag, write enable and load flag through
//               EX/MEM/WB with bubble/hold control, a pending-write scoreboard
//               and saturating bubble/hold counters.
// Revision    : 1.0 - initial release
// ============================================================================
module dest_tag_pipeline #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  wire logic           clk,
    input  wire logic           reset,
    dest_tag_pipeline_if.slave  bus
);
    localparam int c_NUM_REGS = 2 ** REG_ADDR_W;

    logic [REG_ADDR_W-1:0] ex_dest_q,  ex_dest_d;
    logic                  ex_rf_q,    ex_rf_d;
    logic                  ex_ld_q,    ex_ld_d;
    logic [REG_ADDR_W-1:0] mem_dest_q, mem_dest_d;
    logic                  mem_rf_q,   mem_rf_d;
    logic                  mem_ld_q,   mem_ld_d;
    logic [REG_ADDR_W-1:0] wb_dest_q,  wb_dest_d;
    logic                  wb_rf_q,    wb_rf_d;
    logic [CNT_W-1:0]      bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0]      hold_cnt_q,   hold_cnt_d;

    logic                  w_bubble;
    logic                  w_id_nonzero;
    logic                  w_id_rf;
    logic                  w_id_ld;
    logic [c_NUM_REGS-1:0] w_pending;

    assign w_bubble     = bus.flush | bus.nop_signal;
    assign w_id_nonzero = |bus.id_destination;
    // Writes to r0 are discarded, so they never create a hazard or load stall
    assign w_id_rf      = bus.id_rf_enable & w_id_nonzero;
    assign w_id_ld      = bus.id_load_instruction & w_id_rf;

    always_comb begin
        ex_dest_d    = ex_dest_q;
        ex_rf_d      = ex_rf_q;
        ex_ld_d      = ex_ld_q;
        mem_dest_d   = mem_dest_q;
        mem_rf_d     = mem_rf_q;
        mem_ld_d     = mem_ld_q;
        wb_dest_d    = wb_dest_q;
        wb_rf_d      = wb_rf_q;
        bubble_cnt_d = bubble_cnt_q;
        hold_cnt_d   = hold_cnt_q;

        if (bus.hold) begin
            if (!(&hold_cnt_q)) begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
        end else begin
            wb_dest_d  = mem_dest_q;
            wb_rf_d    = mem_rf_q;
            mem_dest_d = ex_dest_q;
            mem_rf_d   = ex_rf_q;
            mem_ld_d   = ex_ld_q;
            if (w_bubble) begin
                ex_dest_d = '0;
                ex_rf_d   = 1'b0;
                ex_ld_d   = 1'b0;
                if (!(&bubble_cnt_q)) begin
                    bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
                end
            end else begin
                ex_dest_d = bus.id_destination;
                ex_rf_d   = w_id_rf;
                ex_ld_d   = w_id_ld;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_dest_q    <= '0;
            ex_rf_q      <= 1'b0;
            ex_ld_q      <= 1'b0;
            mem_dest_q   <= '0;
            mem_rf_q     <= 1'b0;
            mem_ld_q     <= 1'b0;
            wb_dest_q    <= '0;
            wb_rf_q      <= 1'b0;
            bubble_cnt_q <= '0;
            hold_cnt_q   <= '0;
        end else begin
            ex_dest_q    <= ex_dest_d;
            ex_rf_q      <= ex_rf_d;
            ex_ld_q      <= ex_ld_d;
            mem_dest_q   <= mem_dest_d;
            mem_rf_q     <= mem_rf_d;
            mem_ld_q     <= mem_ld_d;
            wb_dest_q    <= wb_dest_d;
            wb_rf_q      <= wb_rf_d;
            bubble_cnt_q <= bubble_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    for (genvar gi = 0; gi < c_NUM_REGS; gi++) begin : g_pending
        if (gi == 0) begin : g_r0
            assign w_pending[gi] = 1'b0;
        end else begin : g_rn
            assign w_pending[gi] =
                (ex_rf_q  && (ex_dest_q  == REG_ADDR_W'(gi))) ||
                (mem_rf_q && (mem_dest_q == REG_ADDR_W'(gi))) ||
                (wb_rf_q  && (wb_dest_q  == REG_ADDR_W'(gi)));
        end
    end

    assign bus.ex_destination       = ex_dest_q;
    assign bus.mem_destination      = mem_dest_q;
    assign bus.wb_destination       = wb_dest_q;
    assign bus.ex_rf_enable         = ex_rf_q;
    assign bus.mem_rf_enable        = mem_rf_q;
    assign bus.wb_rf_enable         = wb_rf_q;
    assign bus.ex_load_instruction  = ex_ld_q;
    assign bus.mem_load_instruction = mem_ld_q;
    assign bus.pending_mask         = w_pending;
    assign bus.bubble_count         = bubble_cnt_q;
    assign bus.hold_count           = hold_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dest_tag_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : tb_dest_tag_pipeline
// Description : Self-checking bench for dest_tag_pipeline (4-bit counters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dest_tag_pipeline;
    localparam int c_AW   = 5;
    localparam int c_CW   = 4;
    localparam int c_CMAX = 15;

    logic clk;
    logic reset;

    dest_tag_pipeline_if #(.REG_ADDR_W(c_AW), .CNT_W(c_CW)) bus ();

    dest_tag_pipeline #(.REG_ADDR_W(c_AW), .CNT_W(c_CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a three-slot pipeline list, slot 0 = EX, 1 = MEM, 2 = WB
    typedef struct packed {
        logic [c_AW-1:0] d;
        logic            rf;
        logic            ld;
    } ent_t;

    ent_t m_st [3];
    int   m_bub;
    int   m_hld;
    bit   m_valid = 1'b0;

    always @(posedge clk) begin
        ent_t nw;
        if (reset) begin
            for (int s = 0; s < 3; s++) m_st[s] = '0;
            m_bub   = 0;
            m_hld   = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (bus.hold) begin
                m_hld = (m_hld < c_CMAX) ? m_hld + 1 : c_CMAX;
            end else begin
                if (bus.flush || bus.nop_signal) begin
                    nw    = '0;
                    m_bub = (m_bub < c_CMAX) ? m_bub + 1 : c_CMAX;
                end else begin
                    nw.d  = bus.id_destination;
                    nw.rf = bus.id_rf_enable && (bus.id_destination != 0);
                    nw.ld = nw.rf && bus.id_load_instruction;
                end
                m_st[2] = m_st[1];
                m_st[1] = m_st[0];
                m_st[0] = nw;
            end
        end
    end

    function automatic logic [31:0] model_pending();
        logic [31:0] m = '0;
        for (int r = 1; r < 32; r++)
            for (int s = 0; s < 3; s++)
                if (m_st[s].rf && m_st[s].d == r) m[r] = 1'b1;
        return m;
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            chk("ex_dest",  32'(bus.ex_destination),       32'(m_st[0].d));
            chk("mem_dest", 32'(bus.mem_destination),      32'(m_st[1].d));
            chk("wb_dest",  32'(bus.wb_destination),       32'(m_st[2].d));
            chk("ex_rf",    32'(bus.ex_rf_enable),         32'(m_st[0].rf));
            chk("mem_rf",   32'(bus.mem_rf_enable),        32'(m_st[1].rf));
            chk("wb_rf",    32'(bus.wb_rf_enable),         32'(m_st[2].rf));
            chk("ex_ld",    32'(bus.ex_load_instruction),  32'(m_st[0].ld));
            chk("mem_ld",   32'(bus.mem_load_instruction), 32'(m_st[1].ld));
            chk("pending",  bus.pending_mask,              model_pending());
            chk("bubbles",  32'(bus.bubble_count),         32'(m_bub));
            chk("holds",    32'(bus.hold_count),           32'(m_hld));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.id_destination = '0; bus.id_rf_enable = 1'b0; bus.id_load_instruction = 1'b0;
        bus.nop_signal = 1'b0; bus.flush = 1'b0; bus.hold = 1'b0;
    endtask

    task automatic issue(input int d, input bit rf, input bit ld);
        bus.id_destination = c_AW'(d); bus.id_rf_enable = rf; bus.id_load_instruction = ld;
    endtask

    task automatic do_reset();
        idle(); reset = 1'b1; cyc(); reset = 1'b0;
    endtask

    initial begin
        int p5;
        reset = 1'b1;
        idle();
        cyc();
        chk("rst_ex_dest", 32'(bus.ex_destination), 32'd0);
        chk("rst_pending", bus.pending_mask, 32'd0);
        chk("rst_bubbles", 32'(bus.bubble_count), 32'd0);
        reset = 1'b0;

        // Single write to r5 walks EX -> MEM -> WB and then retires
        issue(5, 1, 0); cyc(); idle();
        p5 = int'(bus.pending_mask[5]);
        chk("t1_ex_dest", 32'(bus.ex_destination), 32'd5);
        cyc(); p5 += int'(bus.pending_mask[5]);
        chk("t1_mem_dest", 32'(bus.mem_destination), 32'd5);
        cyc(); p5 += int'(bus.pending_mask[5]);
        chk("t1_wb_dest", 32'(bus.wb_destination), 32'd5);
        cyc(); p5 += int'(bus.pending_mask[5]);
        cyc(); p5 += int'(bus.pending_mask[5]);
        chk("t1_pend5_cycles", 32'(p5), 32'd3);

        // Load to r7 followed by a nop bubble
        do_reset();
        issue(7, 1, 1); cyc();
        issue(9, 1, 0); bus.nop_signal = 1'b1; cyc(); idle();
        chk("t2_ex_rf", 32'(bus.ex_rf_enable), 32'd0);
        chk("t2_ex_dest", 32'(bus.ex_destination), 32'd0);
        chk("t2_mem_ld", 32'(bus.mem_load_instruction), 32'd1);
        chk("t2_mem_dest", 32'(bus.mem_destination), 32'd7);
        chk("t2_bubbles", 32'(bus.bubble_count), 32'd1);

        // Hold freezes tags 3/4/6
        do_reset();
        issue(6, 1, 0); cyc(); issue(4, 1, 0); cyc(); issue(3, 1, 0); cyc();
        issue(11, 1, 0); bus.hold = 1'b1; bus.nop_signal = 1'b1;
        repeat (4) cyc();
        chk("t3_ex", 32'(bus.ex_destination), 32'd3);
        chk("t3_mem", 32'(bus.mem_destination), 32'd4);
        chk("t3_wb", 32'(bus.wb_destination), 32'd6);
        chk("t3_holds", 32'(bus.hold_count), 32'd4);
        chk("t3_bubbles", 32'(bus.bubble_count), 32'd0);
        idle(); cyc();
        chk("t3_resume_mem", 32'(bus.mem_destination), 32'd3);
        chk("t3_resume_wb", 32'(bus.wb_destination), 32'd4);

        // Write to r0 is never pending
        do_reset();
        issue(0, 1, 1); cyc(); idle();
        chk("t4_ex_rf", 32'(bus.ex_rf_enable), 32'd0);
        chk("t4_ex_ld", 32'(bus.ex_load_instruction), 32'd0);
        chk("t4_pending", bus.pending_mask, 32'd0);

        // flush+nop under hold, then without hold
        do_reset();
        issue(2, 1, 0); cyc();
        bus.hold = 1'b1; bus.flush = 1'b1; bus.nop_signal = 1'b1; cyc();
        chk("t5_hold_ex", 32'(bus.ex_destination), 32'd2);
        chk("t5_hold_bub", 32'(bus.bubble_count), 32'd0);
        bus.hold = 1'b0; cyc(); idle();
        chk("t5_bub", 32'(bus.bubble_count), 32'd1);
        chk("t5_mem", 32'(bus.mem_destination), 32'd2);
        chk("t5_pending", bus.pending_mask, 32'h0000_0004);

        // Counter saturation and mid-pipeline reset
        do_reset();
        bus.nop_signal = 1'b1; repeat (20) cyc(); idle();
        chk("t6_bub_sat", 32'(bus.bubble_count), 32'd15);
        bus.hold = 1'b1; repeat (20) cyc(); idle();
        chk("t6_hold_sat", 32'(bus.hold_count), 32'd15);
        issue(12, 1, 1); cyc(); issue(13, 1, 0); cyc();
        reset = 1'b1; cyc(); reset = 1'b0; idle();
        chk("t6_rst_ex", 32'(bus.ex_destination), 32'd0);
        chk("t6_rst_mem", 32'(bus.mem_destination), 32'd0);
        chk("t6_rst_pending", bus.pending_mask, 32'd0);
        chk("t6_rst_bub", 32'(bus.bubble_count), 32'd0);

        // Randomized traffic against the reference
        for (int i = 0; i < 3000; i++) begin
            bus.id_destination      = c_AW'($urandom_range(0, 31));
            bus.id_rf_enable        = ($urandom_range(0, 3) != 0);
            bus.id_load_instruction = $urandom_range(0, 1) == 1;
            bus.nop_signal          = ($urandom_range(0, 5) == 0);
            bus.flush               = ($urandom_range(0, 9) == 0);
            bus.hold                = ($urandom_range(0, 7) == 0);
            reset                   = ($urandom_range(0, 199) == 0);
            cyc();
        end
        reset = 1'b0; idle(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
